// File: rtl/spi_slave.sv
// SPI target engine. Oversamples external SCLK/CS/MOSI in the clk_i domain,
// assembles received bytes for the RX FIFO and returns TX FIFO bytes on MISO,
// MSB first. Clock polarity and phase are fixed at elaboration time.
module spi_slave #(
  parameter logic       CPOL     = 1'b0,
  parameter logic       CPHA     = 1'b0,
  parameter logic [7:0] IdleByte = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_clk_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Synchronizer chains. The third stage of SCLK and CS provides edge detect.
  logic r_sclk_q1, r_sclk_q2, r_sclk_q3;
  logic r_cs_q1, r_cs_q2, r_cs_q3;
  logic r_mosi_q1, r_mosi_q2;

  // Datapath state. MISO itself holds bit 7 of the current TX byte, so the
  // TX shifter only needs the seven bits still to be sent; likewise the RX
  // shifter only needs the seven bits preceding the one being sampled.
  logic [6:0] r_tx_shift;
  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_data;
  logic       r_miso;
  logic       r_tx_ready;
  logic       r_rx_valid;
  logic       r_tx_underrun;

  // Edge and control strobes.
  logic       w_sclk_rise, w_sclk_fall;
  logic       w_lead_edge, w_trail_edge;
  logic       w_sample_edge, w_shift_edge;
  logic       w_cs_fall;
  logic       w_start, w_stop;
  logic       w_do_sample, w_do_shift;
  logic       w_load, w_shift_only;
  logic [7:0] w_load_byte;

  // Two-flop synchronizers plus an edge-detect stage, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sclk_q1 <= 1'b0;
      r_sclk_q2 <= 1'b0;
      r_sclk_q3 <= 1'b0;
      r_cs_q1   <= 1'b0;
      r_cs_q2   <= 1'b0;
      r_cs_q3   <= 1'b0;
      r_mosi_q1 <= 1'b0;
      r_mosi_q2 <= 1'b0;
    end else begin
      r_sclk_q1 <= spi_clk_i;
      r_sclk_q2 <= r_sclk_q1;
      r_sclk_q3 <= r_sclk_q2;
      r_cs_q1   <= spi_cs_i;
      r_cs_q2   <= r_cs_q1;
      r_cs_q3   <= r_cs_q2;
      r_mosi_q1 <= spi_mosi_i;
      r_mosi_q2 <= r_mosi_q1;
    end
  end

  assign w_sclk_rise   = r_sclk_q2 & ~r_sclk_q3;
  assign w_sclk_fall   = ~r_sclk_q2 & r_sclk_q3;
  assign w_lead_edge   = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail_edge  = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = CPHA ? w_trail_edge : w_lead_edge;
  assign w_shift_edge  = CPHA ? w_lead_edge : w_trail_edge;

  // A real high-to-low transition is required to start a frame. Because the
  // CS chain resets to 0, a CS held low across reset never looks like a fall
  // until it has been released and asserted again.
  assign w_cs_fall = r_cs_q3 & ~r_cs_q2;

  assign w_load_byte = tx_valid_i ? tx_data_i : IdleByte;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle action strobes; SCLK edges only count
  // while ACTIVE, and a CS release wins over any coincident SCLK edge.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_do_sample  = 1'b0;
    w_do_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ST_ACTIVE;
          w_start      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (r_cs_q2) begin
          w_state_next = ST_IDLE;
          w_stop       = 1'b1;
        end else begin
          w_do_sample = w_sample_edge;
          w_do_shift  = w_shift_edge;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A shift edge with bit_cnt==0 is the start of a byte for CPHA=1 and the
  // edge right after the 8th sample for CPHA=0; CPHA=0 additionally loads
  // the first byte as soon as the frame opens.
  assign w_load       = (w_start && (CPHA == 1'b0)) || (w_do_shift && (r_bit_cnt == 3'd0));
  assign w_shift_only = w_do_shift && (r_bit_cnt != 3'd0);

  // TX path: byte load with FIFO pop / underrun strobe, then MSB-first shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_shift    <= 7'd0;
      r_miso        <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (w_stop) begin
        r_miso <= 1'b0;
      end else if (w_load) begin
        r_tx_shift    <= w_load_byte[6:0];
        r_miso        <= w_load_byte[7];
        r_tx_ready    <= tx_valid_i;
        r_tx_underrun <= ~tx_valid_i;
      end else if (w_shift_only) begin
        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end
    end
  end

  // RX path: sample MOSI, count bits, publish the byte on the 7->0 wrap.
  // A frame that ends mid-byte simply resets the count; nothing is published.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_shift <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_start || w_stop) begin
        r_rx_shift <= 7'd0;
        r_bit_cnt  <= 3'd0;
      end else if (w_do_sample) begin
        r_rx_shift <= {r_rx_shift[5:0], r_mosi_q2};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= {r_rx_shift, r_mosi_q2};
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  assign spi_miso_o    = r_miso;
  assign tx_ready_o    = r_tx_ready;
  assign tx_underrun_o = r_tx_underrun;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  // Reported from the FSM so that a CS left low across reset does not show
  // as busy until a proper frame has started.
  assign busy_o        = (r_state == ST_ACTIVE);

endmodule
